// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit.
//   master: drives start_i, op_i, opdata1_i, opdata2_i, annul_i; observes the outputs.
//   slave : the unit itself; drives busy_o, ready_o, result_o ({hi,lo}), div_by_zero_o.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                   start_i;
  logic [1:0]             op_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   annul_i;
  logic                   busy_o;
  logic                   ready_o;
  logic [2*WIDTH-1:0]     result_o;
  logic                   div_by_zero_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  busy_o, ready_o, result_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output busy_o, ready_o, result_o, div_by_zero_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit.
//   op_i: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
//   Multiplies are shift-add over magnitudes, divides are radix-2 restoring division over
//   magnitudes; both spend WIDTH cycles in StRun and share the a/b/acc datapath registers.
//   Sign fix-up is applied on the edge that leaves StRun, so result_o and div_by_zero_o
//   update together with entry into StDone (ready_o is high in StDone unless annul_i).
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - muldiv_unit_if.slave request/response bundle
// Configuration:
//   MULDIV_FAST_MUL_EN - when defined, MULT/MULTU are computed in one registered step and
//                        go straight from acceptance to StDone (busy_o never rises).
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  // a: dividend/quotient or multiplier/product-lo; b: divisor or multiplicand;
  // acc: partial remainder or product-hi.
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 neg_q, neg_d;        // negate quotient / product
  logic                 rneg_q, rneg_d;      // negate remainder
  logic                 dbz_pend_q, dbz_pend_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q;
  logic                 rst_done_q;          // blocks acceptance on the first edge after reset

  // Operand preparation at acceptance.
  logic                 sgn1, sgn2, op2_zero;
  logic [WIDTH-1:0]     mag1, mag2;
  logic                 neg_ld, rneg_ld;
  logic                 accept;
  logic                 fast_mul;
  logic [2*WIDTH-1:0]   fast_prod;

  assign sgn1     = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
  assign sgn2     = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
  assign mag1     = sgn1 ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2     = sgn2 ? -bus.opdata2_i : bus.opdata2_i;
  assign op2_zero = (bus.opdata2_i == '0);
  // A zero divisor must leave the all-ones quotient untouched.
  assign neg_ld   = (sgn1 ^ sgn2) & ~(bus.op_i[1] & op2_zero);
  assign rneg_ld  = bus.op_i[1] & sgn1;
  assign accept   = rst_done_q & bus.start_i & ~bus.annul_i;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext1, ext2;
  assign ext1      = {{WIDTH{sgn1}}, bus.opdata1_i};
  assign ext2      = {{WIDTH{sgn2}}, bus.opdata2_i};
  assign fast_mul  = ~bus.op_i[1];
  assign fast_prod = ext1 * ext2;
`else
  assign fast_mul  = 1'b0;
  assign fast_prod = '0;
`endif

  // One iteration of the shared datapath.
  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     a_step, acc_step;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod, prod_fix;

  always_comb begin
    trial    = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    sum      = {1'b0, acc_q} + ({(WIDTH+1){a_q[0]}} & {1'b0, b_q});
    a_step   = a_q;
    acc_step = acc_q;
    if (op_q[1]) begin
      // Restoring step: keep the subtraction only if it did not go negative.
      if (!trial[WIDTH]) begin
        acc_step = trial[WIDTH-1:0];
        a_step   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
        a_step   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: {acc,a} shifts right, consumed multiplier bits fall off a.
      acc_step = sum[WIDTH:1];
      a_step   = {sum[0], a_q[WIDTH-1:1]};
    end
    quo_fix  = neg_q ? -a_step : a_step;
    rem_fix  = rneg_q ? -acc_step : acc_step;
    prod     = {acc_step, a_step};
    prod_fix = neg_q ? -prod : prod;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dbz_pend_d = dbz_pend_q;
    result_d   = result_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          op_d       = bus.op_i;
          a_d        = mag1;
          b_d        = mag2;
          acc_d      = '0;
          neg_d      = neg_ld;
          rneg_d     = rneg_ld;
          dbz_pend_d = bus.op_i[1] & op2_zero;
          if (fast_mul) begin
            state_d  = StDone;
            result_d = fast_prod;
            dbz_d    = 1'b0;
          end else begin
            state_d  = StRun;
            cnt_d    = CntW'(WIDTH);
          end
        end
      end
      StRun: begin
        if (bus.annul_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          a_d   = a_step;
          acc_d = acc_step;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d  = StDone;
            result_d = op_q[1] ? {rem_fix, quo_fix} : prod_fix;
            dbz_d    = op_q[1] & dbz_pend_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dbz_pend_q <= dbz_pend_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      busy_q     <= (state_d == StRun);
      rst_done_q <= 1'b1;
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.ready_o       = (state_q == StDone) & ~bus.annul_i;
  assign bus.result_o      = result_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): reset values, divide/multiply vectors with
// hand-computed results and latencies, zero divisor, overflow divide, annul and reset abort.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpMult  = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpDiv   = 2'b11;
  localparam int DivLat = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait for ready_o (bounded).
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res,
                        input logic exp_dbz);
    int          lat;
    logic [63:0] res_before;
    res_before    = bus.result_o;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    bus.op_i      = 2'($urandom);
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    lat = 1;
    chk({tag, " busy"}, 64'(bus.busy_o), 64'(exp_lat > 1));
    if (exp_lat > 1) chk({tag, " held"}, bus.result_o, res_before);
    while (bus.ready_o !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, bus.result_o, exp_res);
    chk({tag, " dbz"}, 64'(bus.div_by_zero_o), 64'(exp_dbz));
  endtask

  initial begin
    int          ready_cnt;
    int          busy_cnt;
    logic [63:0] prior;

    bus.start_i   = 1'b0;
    bus.op_i      = 2'b00;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    resetn        = 1'b1;
    #2 resetn     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(bus.busy_o), 64'd0);
    chk("rst ready", 64'(bus.ready_o), 64'd0);
    chk("rst result", bus.result_o, 64'd0);
    chk("rst dbz", 64'(bus.div_by_zero_o), 64'd0);

    // Start held during release: first edge with resetn high must not accept.
    bus.op_i      = OpDivu;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    resetn        = 1'b1;
    @(posedge clk); #1;
    chk("no accept after release", 64'(bus.busy_o), 64'd0);

    run_op("divu 100/7", OpDivu, 32'd100, 32'd7, DivLat, {32'd2, 32'd14}, 1'b0);
    run_op("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, DivLat, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
           1'b0);
    run_op("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, DivLat, {32'd1, 32'hFFFF_FFFD}, 1'b0);
    run_op("div minneg/-1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, DivLat,
           {32'h0, 32'h8000_0000}, 1'b0);
    run_op("divu x/0", OpDivu, 32'h1234, 32'd0, DivLat, {32'h1234, 32'hFFFF_FFFF}, 1'b1);
    run_op("multu 3*5", OpMultu, 32'd3, 32'd5, MulLat, 64'd15, 1'b0);
    run_op("div -5/0", OpDiv, 32'hFFFF_FFFB, 32'd0, DivLat, {32'hFFFF_FFFB, 32'hFFFF_FFFF},
           1'b1);
    run_op("multu max*max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat,
           64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult minneg^2", OpMult, 32'h8000_0000, 32'h8000_0000, MulLat,
           64'h4000_0000_0000_0000, 1'b0);
    run_op("mult -2*3", OpMult, 32'hFFFF_FFFE, 32'd3, MulLat, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);

    // Annul in RUN at cycle 10 with a simultaneous start.
    prior         = 64'hFFFF_FFFF_FFFF_FFFA;
    bus.op_i      = OpDiv;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'hFFFF_FFF9;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("annul pre busy", 64'(bus.busy_o), 64'd1);
    bus.annul_i   = 1'b1;
    bus.start_i   = 1'b1;
    bus.op_i      = OpDivu;
    @(posedge clk); #1;
    chk("annul busy", 64'(bus.busy_o), 64'd0);
    chk("annul ready", 64'(bus.ready_o), 64'd0);
    chk("annul result kept", bus.result_o, prior);
    // Still annulled in IDLE: the start must be dropped.
    @(posedge clk); #1;
    chk("annul idle start dropped", 64'(bus.busy_o), 64'd0);
    bus.annul_i   = 1'b0;
    bus.start_i   = 1'b0;
    ready_cnt     = 0;
    busy_cnt      = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o === 1'b1) ready_cnt++;
      if (bus.busy_o === 1'b1) busy_cnt++;
    end
    chk("annul no ready", 64'(ready_cnt), 64'd0);
    chk("annul no busy", 64'(busy_cnt), 64'd0);
    chk("annul result still kept", bus.result_o, prior);

    // Annul in DONE suppresses the ready pulse; the result was already written.
    bus.op_i      = OpDivu;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    bus.annul_i   = 1'b1;
    #1;
    chk("done annul ready", 64'(bus.ready_o), 64'd0);
    chk("done annul result", bus.result_o, {32'd0, 32'd10});
    @(posedge clk); #1;
    bus.annul_i   = 1'b0;
    #1;
    chk("done annul after ready", 64'(bus.ready_o), 64'd0);
    chk("done annul after busy", 64'(bus.busy_o), 64'd0);

    // Asynchronous reset mid-RUN.
    bus.op_i      = OpDivu;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun busy before", 64'(bus.busy_o), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midrun rst busy", 64'(bus.busy_o), 64'd0);
    chk("midrun rst ready", 64'(bus.ready_o), 64'd0);
    chk("midrun rst result", bus.result_o, 64'd0);
    chk("midrun rst dbz", 64'(bus.div_by_zero_o), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post rst ready", 64'(bus.ready_o), 64'd0);
    run_op("divu 9/3", OpDivu, 32'd9, 32'd3, DivLat, {32'd0, 32'd3}, 1'b0);

    // ready_o lasts exactly one cycle.
    @(posedge clk); #1;
    chk("ready single pulse", 64'(bus.ready_o), 64'd0);
    chk("final busy", 64'(bus.busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
